serial_adder_ctrl: RTL and testbench

Bit-serial adder controller. Computes an N-bit sum with a single full_adder instance, one bit per clock, LSB first. Sequences the operand and result shift registers and the carry flop, and presents a start/busy/done handshake to the host. Serves as the area-minimal alternative to the ripple N_bit_adder.

---
 rtl/serial_adder_pkg.sv | 15 +
 rtl/full_adder.sv | 13 +
 rtl/serial_adder_ctrl.sv | 106 ++++++++++
 tb/tb_serial_adder_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and helpers for the bit-serial adder
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit-counter width: enough to count WIDTH serial steps (0..WIDTH-1)
  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - one-bit full adder
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder controller, one sum bit per clock, LSB first
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] s_sh_q;
  logic [WIDTH-1:0] s_sh_d;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  logic             s_fa;
  logic             cout_fa;

  // The single adder cell sees the current LSBs and the running carry
  full_adder u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .s    (s_fa),
    .cout (cout_fa)
  );

  // New sum bit enters at the MSB so the LSB-first stream lands in place after WIDTH steps
  assign s_sh_d = {s_fa, s_sh_q[WIDTH-1:1]};

  // Sequencer: operand capture, serial shifting, result commit and handshake flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            carry_q <= cin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          a_sh_q  <= a_sh_q >> 1;
          b_sh_q  <= b_sh_q >> 1;
          s_sh_q  <= s_sh_d;
          carry_q <= cout_fa;
          cnt_q   <= cnt_q + CNT_ONE;
          if (cnt_q == LAST_BIT) begin
            sum_q   <= s_sh_d;
            cout_q  <= cout_fa;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - scoreboard bench for serial_adder_ctrl at WIDTH 8, 2 and 32
module tb_serial_adder_ctrl;

  typedef struct {
    logic [64:0] val;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start_r [3];
  logic [63:0] a_r     [3];
  logic [63:0] b_r     [3];
  logic        cin_r   [3];

  logic        busy8, done8, cout8;
  logic [7:0]  sum8;
  logic        busy2, done2, cout2;
  logic [1:0]  sum2;
  logic        busy32, done32, cout32;
  logic [31:0] sum32;

  int widths [3] = '{8, 2, 32};
  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int busy_run8 = 0;
  int dcyc8 [$];
  exp_t q0 [$];
  exp_t q1 [$];
  exp_t q2 [$];

  serial_adder_ctrl #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start_r[0]), .a(a_r[0][7:0]), .b(b_r[0][7:0]),
    .cin(cin_r[0]), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder_ctrl #(.WIDTH(2)) u2 (
    .clk(clk), .rst(rst), .start(start_r[1]), .a(a_r[1][1:0]), .b(b_r[1][1:0]),
    .cin(cin_r[1]), .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
  );

  serial_adder_ctrl #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst), .start(start_r[2]), .a(a_r[2][31:0]), .b(b_r[2][31:0]),
    .cin(cin_r[2]), .busy(busy32), .done(done32), .sum(sum32), .cout(cout32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int qsize(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic push(input int k, input exp_t e);
    case (k)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic pop(input int k, output exp_t e);
    case (k)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
  endtask

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic [64:0] model(input int w, input logic [63:0] a, input logic [63:0] b, input logic c);
    logic [64:0] mw;
    logic [64:0] mr;
    mw = (65'd1 << w) - 65'd1;
    mr = (65'd1 << (w + 1)) - 65'd1;
    return (({1'b0, a} & mw) + ({1'b0, b} & mw) + {64'd0, c}) & mr;
  endfunction

  // Monitor: pops the scoreboard whenever any instance pulses done
  always @(negedge clk) begin
    if (rst) begin
      busy_run8 = 0;
    end else begin
      if (busy8) busy_run8++;
      for (int k = 0; k < 3; k++) begin
        logic        dn;
        logic        bs;
        logic [64:0] res;
        exp_t        e;
        case (k)
          0:       begin dn = done8;  bs = busy8;  res = {56'd0, cout8, sum8};   end
          1:       begin dn = done2;  bs = busy2;  res = {62'd0, cout2, sum2};   end
          default: begin dn = done32; bs = busy32; res = {32'd0, cout32, sum32}; end
        endcase
        if (dn) begin
          check($sformatf("busy_with_done_w%0d", widths[k]), {64'd0, bs}, 65'd0);
          if (qsize(k) == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_done_w%0d: done=1 at cycle %0d, expected no done", widths[k], cyc);
          end else begin
            pop(k, e);
            check($sformatf("result_w%0d", widths[k]), res, e.val);
            check($sformatf("latency_w%0d", widths[k]), 65'(cyc), 65'(e.cyc));
          end
          if (k == 0) begin
            check("busy_cycles_w8", 65'(busy_run8), 65'd8);
            busy_run8 = 0;
            dcyc8.push_back(cyc);
          end
        end
      end
    end
  end

  task automatic do_op(input int k, input logic [63:0] a, input logic [63:0] b, input logic c);
    exp_t e;
    @(negedge clk);
    a_r[k] = a; b_r[k] = b; cin_r[k] = c; start_r[k] = 1'b1;
    @(posedge clk);
    #1;
    e.val = model(widths[k], a, b, c);
    e.cyc = cyc + widths[k];
    push(k, e);
    @(negedge clk);
    start_r[k] = 1'b0;
  endtask

  task automatic drain(input int k);
    int t = 0;
    while (qsize(k) != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (qsize(k) != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout_w%0d: %0d results outstanding, expected 0", widths[k], qsize(k));
    end
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    int   n0;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      start_r[k] = 1'b0; a_r[k] = '0; b_r[k] = '0; cin_r[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", {64'd0, busy8}, 65'd0);
    check("reset_done", {64'd0, done8}, 65'd0);
    check("reset_sum",  {57'd0, sum8},  65'd0);
    check("reset_cout", {64'd0, cout8}, 65'd0);
    rst = 1'b0;

    // Basic add, then result must hold through idle
    do_op(0, 64'h3C, 64'h0F, 1'b0);
    drain(0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("hold_sum", {56'd0, cout8, sum8}, {56'd0, 1'b0, 8'h4B});
    end

    // Carry boundaries
    do_op(0, 64'hFF, 64'h01, 1'b0); drain(0);
    do_op(0, 64'hFF, 64'hFF, 1'b1); drain(0);
    do_op(0, 64'h00, 64'h00, 1'b1); drain(0);

    // start re-pulsed mid-RUN is ignored
    do_op(0, 64'h05, 64'h03, 1'b0);
    repeat (2) @(negedge clk);
    a_r[0] = 64'h11; b_r[0] = 64'h22; start_r[0] = 1'b1;
    @(negedge clk);
    start_r[0] = 1'b0;
    drain(0);
    repeat (12) @(negedge clk);
    check("ignored_start_sum", {57'd0, sum8}, 65'h08);
    check("ignored_start_busy", {64'd0, busy8}, 65'd0);

    // Back-to-back with start held high
    n0 = dcyc8.size();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       begin a_r[0] = 64'h01; b_r[0] = 64'h02; end
        1:       begin a_r[0] = 64'h80; b_r[0] = 64'h80; end
        default: begin a_r[0] = 64'h7F; b_r[0] = 64'h01; end
      endcase
      cin_r[0] = 1'b0;
      start_r[0] = 1'b1;
      @(posedge clk);
      #1;
      e.val = model(8, a_r[0], b_r[0], 1'b0);
      e.cyc = cyc + 8;
      push(0, e);
      @(negedge clk);
      if (i == 2) start_r[0] = 1'b0;
      repeat (8) @(negedge clk);
    end
    start_r[0] = 1'b0;
    drain(0);
    if (dcyc8.size() >= n0 + 3) begin
      check("b2b_spacing_1", 65'(dcyc8[n0 + 1] - dcyc8[n0]), 65'd9);
      check("b2b_spacing_2", 65'(dcyc8[n0 + 2] - dcyc8[n0 + 1]), 65'd9);
    end else begin
      tests++;
      fails++;
      $display("FAIL b2b_done_count: got %0d, expected 3", dcyc8.size() - n0);
    end

    // Asynchronous reset mid-RUN aborts with no done
    check("pre_reset_sum", {57'd0, sum8}, 65'h80);
    @(negedge clk);
    a_r[0] = 64'h33; b_r[0] = 64'h44; cin_r[0] = 1'b0; start_r[0] = 1'b1;
    @(posedge clk);
    #1;
    start_r[0] = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_busy", {64'd0, busy8}, 65'd0);
    check("abort_done", {64'd0, done8}, 65'd0);
    check("abort_sum",  {57'd0, sum8},  65'd0);
    check("abort_cout", {64'd0, cout8}, 65'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    do_op(0, 64'h10, 64'h10, 1'b0);
    drain(0);

    // Width extremes
    do_op(1, 64'h3, 64'h1, 1'b0);
    drain(1);
    do_op(1, 64'h2, 64'h1, 1'b1);
    drain(1);
    do_op(2, 64'hFFFF_FFFF, 64'h1, 1'b0);
    drain(2);
    do_op(2, 64'h1234_5678, 64'h9ABC_DEF0, 1'b1);
    drain(2);

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
